// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states, command and
// response records, and the legality rule applied when a command is popped.
package alu_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_XOR = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       cin;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  typedef struct packed {
    logic [15:0] result;
    logic        cout;
    logic        zero;
    logic        err;
  } rsp_t;

  localparam rsp_t RSP_RESET = '{result: '0, cout: 1'b0, zero: 1'b1, err: 1'b0};

  // Unknown opcodes and divide-by-zero never reach the ALU.
  function automatic logic cmd_illegal(input cmd_t c);
    return (c.op > 4'd5) || ((c.op == OP_DIV) && (c.b == 8'd0));
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Power-of-two circular command FIFO; pointers wrap naturally at DEPTH.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [CMD_W-1:0]         data_i,
  output logic [CMD_W-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues one at a time to a registered ALU, and holds
// each response until the consumer accepts it.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_op,
  input  logic        cmd_cin,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [3:0]  alu_op_code,
  output logic        alu_C_in,
  input  logic [15:0] alu_Result,
  input  logic        alu_C_out,
  input  logic        alu_Z_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_cout,
  output logic        rsp_zero,
  output logic        rsp_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  cmd_t             alu_q, alu_d;
  rsp_t             rsp_q, rsp_d;
  cmd_t             head;
  logic [CMD_W-1:0] push_bits, head_bits;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign push_bits = {cmd_a, cmd_b, cmd_op, cmd_cin};
  assign head      = cmd_t'(head_bits);
  assign cmd_ready = !Reset && (fifo_count < CW'(DEPTH));
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (push_bits),
    .data_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    assert (fifo_full == (fifo_count == CW'(DEPTH)));
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      alu_q   <= '0;
      rsp_q   <= RSP_RESET;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = cmd_illegal(head) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ALU operands move only when a legal command leaves IDLE; an illegal one
  // writes its error response directly and leaves the ALU inputs alone.
  always_comb begin
    alu_d = alu_q;
    rsp_d = rsp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (cmd_illegal(head)) rsp_d = '{result: '0, cout: 1'b0, zero: 1'b1, err: 1'b1};
          else                   alu_d = head;
        end
      end
      ST_CAPT: begin
        rsp_d.result = alu_Result;
        rsp_d.cout   = (alu_q.op == OP_ADD) && alu_C_out;
        rsp_d.zero   = alu_Z_flag;
        rsp_d.err    = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    rsp_valid   = (state_q == ST_RESP);
    rsp_result  = rsp_q.result;
    rsp_cout    = rsp_q.cout;
    rsp_zero    = rsp_q.zero;
    rsp_err     = rsp_q.err;
    alu_A       = alu_q.a;
    alu_B       = alu_q.b;
    alu_op_code = alu_q.op;
    alu_C_in    = alu_q.cin;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a registered ALU stub and a
// command-level response model; also exercises the FIFO on its own.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] result;
    logic        cout;
    logic        zero;
    logic        err;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset, cmd_valid, cmd_ready, cmd_cin, rsp_valid, rsp_ready;
  logic [7:0]  cmd_a, cmd_b, alu_A, alu_B;
  logic [3:0]  cmd_op, alu_op_code;
  logic        alu_C_in, rsp_cout, rsp_zero, rsp_err;
  logic [15:0] rsp_result;
  logic [15:0] alu_Result = '0;
  logic        alu_C_out = 1'b0;
  logic        alu_Z_flag = 1'b1;

  logic             f_push, f_pop, f_full, f_empty;
  logic [CMD_W-1:0] f_din, f_dout;
  logic [2:0]       f_count;

  int   n_cmp  = 0;
  int   n_fail = 0;
  cmd_t last_legal = '0;
  exp_t exp_q[$];
  logic [CMD_W-1:0] fq[$];

  always #5 CLK = ~CLK;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_cin(cmd_cin),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op_code(alu_op_code), .alu_C_in(alu_C_in),
    .alu_Result(alu_Result), .alu_C_out(alu_C_out), .alu_Z_flag(alu_Z_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  alu_cmd_fifo #(.DEPTH(4)) u_fifo_chk (
    .clk_i(CLK), .rst_i(Reset), .push_i(f_push), .pop_i(f_pop),
    .data_i(f_din), .data_o(f_dout), .full_o(f_full), .empty_o(f_empty), .count_o(f_count)
  );

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op, input logic cin);
    int signed x;
    x = 0;
    case (op)
      4'd0: x = int'(a) + int'(b) + int'(cin);
      4'd1: x = int'(a) - int'(b);
      4'd2: x = int'(a) * int'(b);
      4'd3: x = (b == 0) ? 0 : int'(a) / int'(b);
      4'd4: x = int'(a & b);
      4'd5: x = int'(a ^ b);
      default: x = 0;
    endcase
    return x[15:0];
  endfunction

  // Registered ALU: carry is deliberately 1 for non-ADD ops.
  always @(posedge CLK) begin
    alu_Result <= alu_fn(alu_A, alu_B, alu_op_code, alu_C_in);
    alu_C_out  <= (alu_op_code == 4'd0) ? (alu_fn(alu_A, alu_B, alu_op_code, alu_C_in) > 16'd255) : 1'b1;
    alu_Z_flag <= (alu_fn(alu_A, alu_B, alu_op_code, alu_C_in) == 16'd0);
  end

  function automatic exp_t model(input cmd_t c);
    exp_t e;
    if (c.op > 4'd5 || (c.op == 4'd3 && c.b == 8'd0)) begin
      e = '{result: 16'd0, cout: 1'b0, zero: 1'b1, err: 1'b1};
    end else begin
      e.result = alu_fn(c.a, c.b, c.op, c.cin);
      e.cout   = (c.op == 4'd0) && ((int'(c.a) + int'(c.b) + int'(c.cin)) > 255);
      e.zero   = (e.result == 16'd0);
      e.err    = 1'b0;
    end
    return e;
  endfunction

  function automatic cmd_t rand_cmd(input bit legal_only);
    cmd_t c;
    c.a   = 8'($urandom);
    c.cin = 1'($urandom);
    c.op  = legal_only ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 7));
    c.b   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
    if (legal_only && c.b == 8'd0) c.b = 8'd7;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_cmd(input cmd_t c);
    cmd_a = c.a; cmd_b = c.b; cmd_op = c.op; cmd_cin = c.cin;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_payload(input string tag, input exp_t e);
    check(tag, {13'd0, rsp_result, rsp_cout, rsp_zero, rsp_err}, {13'd0, e});
  endtask

  task automatic check_alu(input string tag);
    check(tag, {11'd0, alu_A, alu_B, alu_op_code, alu_C_in}, {11'd0, last_legal});
  endtask

  // One command into an empty FIFO with an idle FSM, then handshake after hold cycles.
  task automatic run_one(input string tag, input cmd_t c, input int hold);
    exp_t e;
    int   lat;
    e = model(c);
    check({tag, "_ready"}, cmd_ready, 1);
    drive_cmd(c);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check({tag, "_lat"}, lat, e.err ? 1 : 3);
    check_payload({tag, "_rsp"}, e);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check_payload({tag, "_hold_rsp"}, e);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_done"}, rsp_valid, 0);
    if (!e.err) last_legal = c;
    check_alu({tag, "_alu"});
  endtask

  initial begin
    cmd_t c;
    exp_t e;
    int   lat;
    logic seen;

    Reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_cin = 1'b0;
    f_push = 1'b0; f_pop = 1'b0; f_din = '0;
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu", {11'd0, alu_A, alu_B, alu_op_code, alu_C_in}, 0);
    check("rst_rsp", {13'd0, rsp_result, rsp_cout, rsp_zero, rsp_err}, 32'h2);
    Reset = 1'b0;
    #1;
    check("post_rst_ready", cmd_ready, 1);

    run_one("add", '{a: 8'd200, b: 8'd100, op: 4'd0, cin: 1'b1}, 0);
    run_one("div0", '{a: 8'd9, b: 8'd0, op: 4'd3, cin: 1'b0}, 0);
    run_one("bad_op", '{a: 8'd1, b: 8'd2, op: 4'd9, cin: 1'b0}, 1);
    run_one("mul", '{a: 8'd15, b: 8'd17, op: 4'd2, cin: 1'b0}, 10);
    tick();
    check("mul_single_hs", rsp_valid, 0);

    // Five back-to-back pushes with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      c = rand_cmd(1'b1);
      exp_q.push_back(model(c));
      last_legal = c;
      drive_cmd(c);
      cmd_valid = 1'b1;
      check("b2b_accept", cmd_ready, 1);
      tick();
    end
    cmd_valid = 1'b0;
    check("b2b_full", cmd_ready, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(lat);
      check("b2b_timeout", rsp_valid, 1);
      e = exp_q.pop_front();
      check_payload("b2b_rsp", e);
      tick();
    end
    rsp_ready = 1'b0;
    check("b2b_drained", rsp_valid, 0);
    check_alu("b2b_alu");

    for (int i = 0; i < 30; i++) begin
      run_one("rand", rand_cmd(1'b0), $urandom_range(0, 3));
    end

    // Reset while SUB 5-5 is in CAPT.
    drive_cmd('{a: 8'd5, b: 8'd5, op: 4'd1, cin: 1'b0});
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check("capt_no_valid", rsp_valid, 0);
    Reset = 1'b1;
    #1;
    check("capt_rst_ready", cmd_ready, 0);
    tick();
    Reset = 1'b0;
    #1;
    last_legal = '0;
    check("capt_rst_alu", {11'd0, alu_A, alu_B, alu_op_code, alu_C_in}, 0);
    check("capt_rst_rsp", {13'd0, rsp_result, rsp_cout, rsp_zero, rsp_err}, 32'h2);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | rsp_valid;
      tick();
    end
    check("capt_no_rsp", seen, 0);
    run_one("post_rst", '{a: 8'd1, b: 8'd2, op: 4'd0, cin: 1'b0}, 0);

    // Standalone FIFO: steady push+pop at occupancy 2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      f_din = CMD_W'($urandom);
      fq.push_back(f_din);
      f_push = 1'b1;
      tick();
    end
    f_push = 1'b0;
    check("fifo_cnt2", f_count, 2);
    for (int i = 0; i < 8; i++) begin
      f_din = CMD_W'($urandom);
      f_push = 1'b1;
      f_pop = 1'b1;
      check("fifo_head", f_dout, fq[0]);
      tick();
      void'(fq.pop_front());
      fq.push_back(f_din);
      check("fifo_steady_cnt", f_count, 2);
    end
    f_push = 1'b0;
    f_pop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("fifo_drain", f_dout, fq.pop_front());
      tick();
    end
    f_pop = 1'b0;
    check("fifo_empty", f_empty, 1);
    check("fifo_not_full", f_full, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the command FIFO depth (power of two, 2..16).
REQ-002 Single clock and reset: CLK, Reset; reset is synchronous and active-high.
REQ-003 CLK  in  1  clock; all state changes on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  FIFO can accept a command.
REQ-007 cmd_a, cmd_b  in  8 each  operands.
REQ-008 cmd_op  in  4  opcode.
REQ-009 cmd_cin  in  1  carry-in.
REQ-010 alu_A, alu_B  out  8 each  operands to ALU.
REQ-011 alu_op_code  out  4  opcode to ALU.
REQ-012 alu_C_in  out  1  carry-in to ALU.
REQ-013 alu_Result  in  16  registered ALU result.
REQ-014 alu_C_out, alu_Z_flag  in  1 each  registered ALU flags.
REQ-015 rsp_valid  out  1  response present.
REQ-016 rsp_ready  in  1  consumer accepts response.
REQ-017 rsp_result  out  16;  rsp_cout, rsp_zero, rsp_err  out  1 each  response payload.

Function
REQ-018 Push SHALL occur on an edge with cmd_valid && cmd_ready; cmd_ready SHALL be (count < DEPTH), from registered count only.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; same-edge push and pop SHALL leave count unchanged.
REQ-020 FSM states SHALL be IDLE, ISSUE, CAPT, RESP.
REQ-021 IDLE with FIFO non-empty SHALL pop the head on the next edge.
REQ-022 A popped valid command SHALL load alu_A/alu_B/alu_op_code/alu_C_in and go to ISSUE.
REQ-023 A popped illegal command (cmd_op > 5, or cmd_op == 3 with cmd_b == 0) SHALL go directly to RESP with rsp_err=1, rsp_result=0, rsp_cout=0, rsp_zero=1; ALU outputs unchanged.
REQ-024 ISSUE SHALL last exactly one cycle (ALU registers inputs at its end), then go to CAPT.
REQ-025 CAPT SHALL last one cycle, sample alu_Result/alu_C_out/alu_Z_flag into the response register, set rsp_err=0, then go to RESP.
REQ-026 rsp_cout SHALL be forced to 0 for every opcode other than 0 (ADD).
REQ-027 RESP SHALL hold rsp_valid=1 and a stable payload until rsp_ready=1; on that edge it SHALL return to IDLE.
REQ-028 Latency: a legal command pushed into an empty FIFO with an idle FSM on edge E0 SHALL see rsp_valid=1 after E3; an illegal command after E1.
REQ-029 alu_* outputs SHALL change only on the IDLE->ISSUE transition.
REQ-030 Only one command SHALL be in flight; no FIFO pops occur outside IDLE.

Reset
REQ-031 Reset SHALL empty the FIFO, set FSM to IDLE, and drive cmd_ready=0 during reset, then 1 after.
REQ-032 Reset values: alu_A=0, alu_B=0, alu_op_code=0, alu_C_in=0, rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_zero=1, rsp_err=0.
REQ-033 Reset mid-operation SHALL discard the in-flight command and response without emitting rsp_valid.

Structure
REQ-034 Package alu_pkg SHALL hold the opcode enum (ADD=0, SUB=1, MUL=2, DIV=3, AND=4, XOR=5), the FSM state typedef, and the DEPTH default.
REQ-035 The FIFO SHALL be a sub-module alu_cmd_fifo with DEPTH parameter, push/pop/full/empty/count.

Verification
REQ-036 Push ADD a=200 b=100 cin=1, ALU attached -> rsp_result=301, rsp_cout=1, rsp_zero=0, rsp_err=0, rsp_valid after E3.
REQ-037 Push DIV a=9 b=0 -> rsp_err=1, rsp_result=0, rsp_zero=1 after E1; alu_op_code unchanged.
REQ-038 Push 5 commands back-to-back with rsp_ready=0, DEPTH=4 -> cmd_ready low after 4 accepts (one popped into FSM allows 5th); responses in order after rsp_ready released.
REQ-039 Push MUL a=15 b=17, hold rsp_ready=0 for 10 cycles -> payload 255 stable, rsp_valid held, single handshake.
REQ-040 Assert Reset during CAPT of SUB a=5 b=5 -> no rsp_valid, outputs at reset values, FIFO empty.
REQ-041 Simultaneous push and pop at count=2 for 8 cycles -> count stays 2, pointers wrap, data order preserved.
